dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port widths and the forced word size used by DMA beats.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  localparam int DMEM_ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU MEM stage vs. DMA bursts.
// CPU owns the port in IDLE; a granted DMA burst owns it in XFER.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr,
  input  logic [DMEM_ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic [2:0]             cpu_funct3,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_stall,
  input  logic                   dma_req,
  input  logic                   dma_we,
  input  logic [DMEM_ADDR_W-1:0] dma_addr,
  input  logic [3:0]             dma_len,
  input  logic [DATA_W-1:0]      dma_wdata,
  output logic                   dma_gnt,
  output logic                   dma_beat,
  output logic [DATA_W-1:0]      dma_rdata,
  output logic                   dma_done,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic [DMEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [2:0]             mem_funct3,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam int SW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  state_t                 state;
  logic [SW-1:0]          starve_cnt;
  logic [3:0]             beats_left;
  logic [DMEM_ADDR_W-1:0] addr;
  logic                   we;

  logic xfer;
  logic cpu_acc;
  logic gnt;
  logic unused_lsb;

  // Reset gates DMA ownership immediately so a burst aborts cleanly.
  assign xfer    = (state == XFER) && !reset;
  assign cpu_acc = cpu_rd | cpu_wr;
  assign gnt     = !reset && (state == IDLE) && dma_req &&
                   (!cpu_acc || (starve_cnt == SMAX));

  assign dma_gnt    = gnt;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign unused_lsb = ^dma_addr[1:0];

  // Port mux: CPU passthrough unless a burst owns the memory.
  always_comb begin
    mem_rd     = cpu_rd;
    mem_wr     = cpu_wr;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_funct3 = cpu_funct3;
    cpu_stall  = 1'b0;
    dma_beat   = 1'b0;
    dma_done   = 1'b0;
    if (xfer) begin
      dma_beat   = 1'b1;
      mem_rd     = !we;
      mem_wr     = we;
      mem_addr   = addr;
      mem_wdata  = dma_wdata;
      mem_funct3 = FUNCT3_WORD;
      cpu_stall  = cpu_acc;
      dma_done   = (beats_left == 4'd0);
    end
  end

  // Ownership FSM with inline starvation, beat and address counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      beats_left <= '0;
      addr       <= '0;
      we         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt) begin
            state      <= XFER;
            addr       <= {dma_addr[8:2], 2'b00};
            beats_left <= dma_len;
            we         <= dma_we;
            starve_cnt <= '0;
          end else if (dma_req && cpu_acc) begin
            if (starve_cnt != SMAX)
              starve_cnt <= starve_cnt + SW'(1);
          end else begin
            starve_cnt <= '0;
          end
        end
        XFER: begin
          addr <= addr + 9'd4;
          if (beats_left == 4'd0)
            state <= IDLE;
          else
            beats_left <= beats_left - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
